ans_decoder: RTL and testbench

ANS_DECODER -- requirements
Module: ans_decoder

---
 rtl/ans_decoder_if.sv | 56 +++++
 rtl/ans_decoder.sv | 147 ++++++++++++++
 tb/tb_ans_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ans_decoder_if.sv
// Bundle of every non-clock, non-reset signal of the rANS decoder: control, compressed
// chunk input stream, symbol-table lookup port and decoded symbol output stream.
// The master side is the environment (stream source/sink and table). The slave side is the decoder.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

interface ans_decoder_if;
    localparam int TW = `SYM_WIDTH + `CNT_WIDTH;

    // block control
    logic                  start;
    logic [2:0]            n_init;
    logic [15:0]           num_syms;
    logic [TW-1:0]         total_count;
    logic                  done;
    logic                  err;

    // compressed chunk stream, last-emitted chunk first
    logic [`SYM_WIDTH-1:0] in;
    logic                  in_vld;
    logic                  in_rdy;

    // combinational symbol table port
    logic [TW-1:0]         slot;
    logic [`SYM_WIDTH-1:0] lk_sym;
    logic [`CNT_WIDTH-1:0] lk_count;
    logic [TW-1:0]         lk_cum;

    // decoded symbol stream
    logic [`SYM_WIDTH-1:0] out;
    logic                  out_vld;
    logic                  out_rdy;

    modport master (
        output start, n_init, num_syms, total_count,
        output in, in_vld,
        output lk_sym, lk_count, lk_cum,
        output out_rdy,
        input  in_rdy, slot, out, out_vld, done, err
    );

    modport slave (
        input  start, n_init, num_syms, total_count,
        input  in, in_vld,
        input  lk_sym, lk_count, lk_cum,
        input  out_rdy,
        output in_rdy, slot, out, out_vld, done, err
    );
endinterface

// File: rtl/ans_decoder.sv
// Streaming rANS decoder. It builds the initial coder state from n_init chunks. It then
// repeats lookup / emit / renormalise until num_syms symbols are out. At the end it
// flags err when the final state is not the expected M+1.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module ans_decoder (
    input  logic         clk,
    input  logic         rst,
    ans_decoder_if.slave bus
);
    localparam int SW  = `SYM_WIDTH;
    localparam int CW  = `CNT_WIDTH;
    localparam int STW = `STATE_WIDTH;
    localparam int TW  = SW + CW;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] LOOKUP = 3'd2;
    localparam logic [2:0] EMIT   = 3'd3;
    localparam logic [2:0] RENORM = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [STW-1:0] acc_q, acc_d;          // coder state
    logic [2:0]     chunk_cnt_q, chunk_cnt_d;
    logic [15:0]    sym_cnt_q, sym_cnt_d;
    logic [SW-1:0]  sym_q, sym_d;
    logic           err_q, err_d;

    logic [STW-1:0] m_ext;
    logic [STW-1:0] m_plus1;
    logic [STW-1:0] slot_full;
    logic [STW-1:0] quot;
    logic [STW-1:0] lookup_next;
    logic [STW-1:0] shift_in;
    logic           in_rdy_w;
    logic           beat;

    // Decode arithmetic is done at full state width. A shifted-in chunk drops the top bits.
    assign m_ext       = STW'(bus.total_count);
    assign m_plus1     = m_ext + STW'(1);
    assign slot_full   = acc_q % m_ext;
    assign quot        = acc_q / m_ext;
    assign lookup_next = STW'(bus.lk_count) * quot + slot_full - STW'(bus.lk_cum);
    assign shift_in    = {acc_q[STW-SW-1:0], bus.in};

    // The chunk input is ready only while loading, or while renormalising a state below M.
    assign in_rdy_w = (state_q == LOAD) || ((state_q == RENORM) && (acc_q < m_ext));
    assign beat     = bus.in_vld && in_rdy_w;

    // The table index is always presented. It only matters during LOOKUP.
    assign bus.slot    = TW'(slot_full);
    assign bus.in_rdy  = in_rdy_w;
    assign bus.out     = sym_q;
    assign bus.out_vld = (state_q == EMIT);
    assign bus.done    = (state_q == DONE);
    assign bus.err     = err_q;

    // Next-state logic for the control FSM and the datapath registers
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        chunk_cnt_d = chunk_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        sym_d       = sym_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = LOAD;
                    acc_d       = '0;
                    chunk_cnt_d = bus.n_init;
                    sym_cnt_d   = bus.num_syms;
                    err_d       = 1'b0;
                end
            end
            LOAD: begin
                if (beat) begin
                    acc_d       = shift_in;
                    chunk_cnt_d = chunk_cnt_q - 3'd1;
                    // chunk_cnt <= 1 also lets an illegal n_init of 0 leave LOAD after one beat.
                    if (chunk_cnt_q <= 3'd1) begin
                        state_d = (sym_cnt_q == 16'd0) ? DONE : LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                sym_d   = bus.lk_sym;
                acc_d   = lookup_next;
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_rdy) begin
                    sym_cnt_d = sym_cnt_q - 16'd1;
                    state_d   = (sym_cnt_q <= 16'd1) ? DONE : RENORM;
                end
            end
            RENORM: begin
                // The state is compared against M before any chunk is taken in this cycle.
                if (acc_q >= m_ext) begin
                    state_d = LOOKUP;
                end else if (beat) begin
                    acc_d = shift_in;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // err is resolved on entry to DONE, so it is valid together with the done pulse.
        if ((state_d == DONE) && (state_q != DONE)) begin
            err_d = (acc_d != m_plus1);
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            chunk_cnt_q <= '0;
            sym_cnt_q   <= '0;
            sym_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            chunk_cnt_q <= chunk_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ans_decoder.sv
// Directed bench for ans_decoder. It uses a two-symbol table (A: sym1 f=4 c=0, B: sym2 f=4 c=4, M=8).
// A reference decoder model predicts the symbols and err. One monitor checks the DUT against it every cycle.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module tb_ans_decoder;
    localparam int SW  = `SYM_WIDTH;
    localparam int CW  = `CNT_WIDTH;
    localparam int STW = `STATE_WIDTH;
    localparam int TW  = SW + CW;
    localparam int M   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ans_decoder_if bus();

    ans_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tbl_sym [2] = '{1, 2};
    int tbl_f   [2] = '{4, 4};
    int tbl_c   [2] = '{0, 4};

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int exp_err;
    int got_q[$];
    int chunk_q[$];
    int stall_left = 0;
    int stall_seen = 0;

    // Symbol table responds combinationally to slot
    always_comb begin
        bus.lk_sym   = '0;
        bus.lk_count = '0;
        bus.lk_cum   = '0;
        for (int k = 0; k < 2; k++) begin
            if (int'(bus.slot) >= tbl_c[k] && int'(bus.slot) < tbl_c[k] + tbl_f[k]) begin
                bus.lk_sym   = SW'(tbl_sym[k]);
                bus.lk_count = CW'(tbl_f[k]);
                bus.lk_cum   = TW'(tbl_c[k]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference decode: the initial state is the first n_init chunks. Each symbol is found by
    // searching the cumulative table. The state is refilled while below M, except after the last symbol.
    task automatic model_run(input int n_init, input int nsyms, input int nch, input int c0, input int c1);
        int ch [2];
        int x;
        int pos;
        int s;
        int hit;
        ch[0] = c0;
        ch[1] = c1;
        x = 0;
        pos = 0;
        exp_q.delete();
        for (int i = 0; i < n_init && pos < nch; i++) begin
            x = ((x << SW) | ch[pos]) % (1 << STW);
            pos++;
        end
        for (int n = 0; n < nsyms; n++) begin
            s = x % M;
            hit = 0;
            for (int k = 0; k < 2; k++)
                if (s >= tbl_c[k] && s < tbl_c[k] + tbl_f[k]) hit = k;
            exp_q.push_back(tbl_sym[hit]);
            x = (tbl_f[hit] * (x / M) + s - tbl_c[hit]) % (1 << STW);
            if (n != nsyms - 1) begin
                while (x < M && pos < nch) begin
                    x = ((x << SW) | ch[pos]) % (1 << STW);
                    pos++;
                end
            end
        end
        exp_err = (x != M + 1) ? 1 : 0;
    endtask

    // Stream driver: presents queued chunks and applies any requested output stall.
    initial begin
        bus.in      = '0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chunk_q.size() > 0) begin
                    bus.in_vld = 1'b1;
                    bus.in     = SW'(chunk_q[0]);
                    if (bus.in_rdy) void'(chunk_q.pop_front());
                end else begin
                    bus.in_vld = 1'b0;
                end
                if (bus.out_vld && stall_left > 0) begin
                    bus.out_rdy = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_rdy = 1'b1;
                end
            end
        end
    end

    // Monitor: checks output symbols, output stability, in_rdy exclusion and the end-of-block status
    initial begin
        logic          prev_stall;
        logic [SW-1:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.out_vld) begin
                    chk("in_rdy_in_emit", int'(bus.in_rdy), 0);
                    if (prev_stall) chk("out_stable", int'(bus.out), int'(prev_out));
                    if (bus.out_rdy) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_symbol: got %0d expected none", bus.out);
                        end else begin
                            chk("symbol", int'(bus.out), exp_q.pop_front());
                        end
                        got_q.push_back(int'(bus.out));
                    end else begin
                        stall_seen++;
                    end
                    prev_stall = !bus.out_rdy;
                    prev_out   = bus.out;
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus.done) begin
                    chk("err_at_done", int'(bus.err), exp_err);
                    chk("symbols_left_at_done", exp_q.size(), 0);
                    chk("chunks_left_at_done", chunk_q.size(), 0);
                end
            end
        end
    end

    task automatic start_dec(input int n_init, input int nsyms, input int nch, input int c0, input int c1);
        model_run(n_init, nsyms, nch, c0, c1);
        got_q.delete();
        stall_seen = 0;
        if (nch > 0) chunk_q.push_back(c0);
        if (nch > 1) chunk_q.push_back(c1);
        @(posedge clk); #2;
        bus.start    = 1'b1;
        bus.n_init   = 3'(n_init);
        bus.num_syms = 16'(nsyms);
        @(posedge clk); #2;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk); #2;
            if (bus.done) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_in_rdy"},  int'(bus.in_rdy), 0);
        chk({name, "_out_vld"}, int'(bus.out_vld), 0);
        chk({name, "_out"},     int'(bus.out), 0);
        chk({name, "_done"},    int'(bus.done), 0);
        chk({name, "_err"},     int'(bus.err), 0);
        chk({name, "_slot"},    int'(bus.slot), 0);
    endtask

    initial begin
        int n;
        bus.start       = 1'b0;
        bus.n_init      = '0;
        bus.num_syms    = '0;
        bus.total_count = TW'(M);

        // Pin the reference model with hand-derived values: 37 -> B,A and err 0; 38 -> err 1.
        model_run(2, 2, 2, 2, 5);
        chk("model_a_sym0", exp_q[0], 2);
        chk("model_a_sym1", exp_q[1], 1);
        chk("model_a_err", exp_err, 0);
        model_run(2, 2, 2, 2, 6);
        chk("model_b_err", exp_err, 1);
        exp_q.delete();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // No start pulse: a chunk on the bus must stay unconsumed.
        chunk_q.push_back(7);
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        chk("idle_in_rdy", int'(bus.in_rdy), 0);
        chk("idle_chunk_kept", chunk_q.size(), 1);
        chunk_q.delete();

        // Block A: chunks 2,5 -> 37 -> symbols 2,1 -> final 9, no err
        start_dec(2, 2, 2, 2, 5);
        wait_done("a");
        chk("a_count", got_q.size(), 2);
        chk("a_sym0", got_q[0], 2);
        chk("a_sym1", got_q[1], 1);
        chk("a_err", int'(bus.err), 0);
        @(negedge clk); #2;
        chk("a_done_pulse", int'(bus.done), 0);

        // Block B: chunks 2,6 -> 38 -> symbols 2,1 -> final 10, err
        start_dec(2, 2, 2, 2, 6);
        wait_done("b");
        chk("b_count", got_q.size(), 2);
        chk("b_sym0", got_q[0], 2);
        chk("b_sym1", got_q[1], 1);
        chk("b_err", int'(bus.err), 1);
        repeat (3) @(negedge clk);
        #2;
        chk("b_err_sticky", int'(bus.err), 1);

        // Block C: same as A with a 5-cycle output stall
        stall_left = 5;
        start_dec(2, 2, 2, 2, 5);
        wait_done("c");
        chk("c_count", got_q.size(), 2);
        chk("c_sym0", got_q[0], 2);
        chk("c_sym1", got_q[1], 1);
        chk("c_stall_cycles", stall_seen, 5);
        chk("c_err", int'(bus.err), 0);

        // Block D: chunk 9 -> A leaves state 5; renorm takes 3 -> 83 -> slot 3
        start_dec(1, 2, 2, 9, 3);
        n = 0;
        while (got_q.size() < 1 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        chk("d_first_sym_seen", got_q.size(), 1);
        @(negedge clk); #2;
        chk("d_renorm_in_rdy", int'(bus.in_rdy), 1);
        chk("d_renorm_slot", int'(bus.slot), 5);
        @(negedge clk); #2;
        chk("d_after_chunk_in_rdy", int'(bus.in_rdy), 0);
        chk("d_after_chunk_slot", int'(bus.slot), 3);
        wait_done("d");
        chk("d_count", got_q.size(), 2);
        chk("d_sym1", got_q[1], 1);
        chk("d_err", int'(bus.err), 1);

        // Reset in IDLE clears the sticky err and the output register.
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #2;
        check_reset_outputs("idle_rst");

        // Block E: reset mid-LOAD with in_vld high, then decode A again
        start_dec(2, 2, 2, 2, 5);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #2;
        check_reset_outputs("load_rst");
        chunk_q.delete();
        exp_q.delete();
        start_dec(2, 2, 2, 2, 5);
        wait_done("e");
        chk("e_count", got_q.size(), 2);
        chk("e_sym0", got_q[0], 2);
        chk("e_sym1", got_q[1], 1);
        chk("e_err", int'(bus.err), 0);

        // Block F: no symbols; chunks 0,9 give final state 9
        start_dec(2, 0, 2, 0, 9);
        wait_done("f");
        chk("f_count", got_q.size(), 0);
        chk("f_err", int'(bus.err), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1);
    end
endmodule
